// File: rtl/rsa_job_sequencer.sv
// rtl/rsa_job_sequencer.sv - buffers RSA jobs, issues them one at a time to the host, returns tagged results
//
// Ports:
//   clk, rst                                  clock, asynchronous active-high reset
//   job_valid/job_ready, job_message,
//   job_modulus, job_exponent                 job intake into the FIFO
//   rsa_message, rsa_modulus, rsa_exponent    operands to the host (held until the next pop)
//   rsa_start                                 one-cycle start pulse to the host
//   rsa_result, rsa_done                      host result and completion pulse
//   res_valid/res_ready, res_data,
//   res_tag, res_status                       result return (status 00 ok, 01 timeout, 10 bad modulus)
module rsa_job_sequencer #(
    parameter int MOD_W          = 16,
    parameter int EXP_W          = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [MOD_W-1:0] job_message,
    input  logic [MOD_W-1:0] job_modulus,
    input  logic [EXP_W-1:0] job_exponent,
    output logic [MOD_W-1:0] rsa_message,
    output logic [MOD_W-1:0] rsa_modulus,
    output logic [EXP_W-1:0] rsa_exponent,
    output logic             rsa_start,
    input  logic [MOD_W-1:0] rsa_result,
    input  logic             rsa_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [MOD_W-1:0] res_data,
    output logic [7:0]       res_tag,
    output logic [1:0]       res_status
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state;
    logic [MOD_W-1:0] mem_msg [FIFO_DEPTH];
    logic [MOD_W-1:0] mem_mod [FIFO_DEPTH];
    logic [EXP_W-1:0] mem_exp [FIFO_DEPTH];
    logic [7:0]       mem_tag [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [7:0]       tag_cnt;
    logic [TW-1:0]    timer;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [AW-1:0]    rd_idx;

    // MSB of each pointer is the wrap bit: equal indices with differing wrap bits means full.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign job_ready = !full;
    assign push      = job_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign rd_idx    = rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_msg[wr_ptr[AW-1:0]] <= job_message;
            mem_mod[wr_ptr[AW-1:0]] <= job_modulus;
            mem_exp[wr_ptr[AW-1:0]] <= job_exponent;
            mem_tag[wr_ptr[AW-1:0]] <= tag_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                tag_cnt <= tag_cnt + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            rsa_message  <= '0;
            rsa_modulus  <= '0;
            rsa_exponent <= '0;
            rsa_start    <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_tag      <= '0;
            res_status   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        rsa_message  <= mem_msg[rd_idx];
                        rsa_modulus  <= mem_mod[rd_idx];
                        rsa_exponent <= mem_exp[rd_idx];
                        res_tag      <= mem_tag[rd_idx];
                        // A modulus below 2 never reaches the host; ISSUE diverts it to HOLD.
                        rsa_start    <= (mem_mod[rd_idx] >= MOD_W'(2));
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsa_start <= 1'b0;
                    timer     <= '0;
                    if (rsa_modulus < MOD_W'(2)) begin
                        res_data   <= '0;
                        res_status <= 2'b10;
                        res_valid  <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (rsa_done) begin
                        res_data   <= rsa_result;
                        res_status <= 2'b00;
                        res_valid  <= 1'b1;
                        state      <= HOLD;
                    end else if (timer == T_LAST) begin
                        res_data   <= '0;
                        res_status <= 2'b01;
                        res_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb/tb_rsa_job_sequencer.sv - directed self-checking bench for rsa_job_sequencer
module tb_rsa_job_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [15:0] job_message = '0;
    logic [15:0] job_modulus = '0;
    logic [3:0]  job_exponent = '0;
    logic [15:0] rsa_message;
    logic [15:0] rsa_modulus;
    logic [3:0]  rsa_exponent;
    logic        rsa_start;
    logic [15:0] rsa_result = '0;
    logic        rsa_done = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [7:0]  res_tag;
    logic [1:0]  res_status;

    int checks = 0;
    int errors = 0;
    int host_mode = 0;      // 0 ideal host, 1 never completes, 2 completes on the timeout cycle
    bit stray_req = 1'b0;
    int start_count = 0;

    always #5 clk = ~clk;

    rsa_job_sequencer dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_message(job_message), .job_modulus(job_modulus), .job_exponent(job_exponent),
        .rsa_message(rsa_message), .rsa_modulus(rsa_modulus), .rsa_exponent(rsa_exponent),
        .rsa_start(rsa_start), .rsa_result(rsa_result), .rsa_done(rsa_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_status(res_status)
    );

    function automatic logic [15:0] modexp(input logic [15:0] b, input logic [3:0] e, input logic [15:0] m);
        logic [31:0] r;
        logic [31:0] x;
        if (m < 16'd2) return 16'd0;
        r = 32'd1;
        x = {16'd0, b} % {16'd0, m};
        for (int i = 0; i < int'(e); i++) r = (r * x) % {16'd0, m};
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        if (rsa_start) start_count++;
    end

    // Host model: samples start at the edge that ends the pulse, raises done e+1 edges later.
    int          host_cd = 0;
    bit          host_busy = 1'b0;
    bit          host_fire;
    bit          host_stray;
    logic [15:0] host_pend = '0;
    always @(posedge clk) begin
        host_fire  = 1'b0;
        host_stray = stray_req;
        if (rst) begin
            host_busy = 1'b0;
        end else begin
            if (host_busy) begin
                host_cd--;
                if (host_cd == 0) begin
                    host_fire = 1'b1;
                    host_busy = 1'b0;
                end
            end
            if (rsa_start) begin
                host_busy = (host_mode != 1);
                host_cd   = (host_mode == 2) ? 63 : int'(rsa_exponent) + 1;
                host_pend = modexp(rsa_message, rsa_exponent, rsa_modulus);
            end
        end
        #1;
        rsa_done   = host_fire | host_stray;
        rsa_result = host_fire ? host_pend : 16'hdead;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        job_valid = 1'b0;
        res_ready = 1'b0;
        host_mode = 0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic send_job(input logic [15:0] m, input logic [15:0] md, input logic [3:0] e);
        job_message  = m;
        job_modulus  = md;
        job_exponent = e;
        job_valid    = 1'b1;
        for (int i = 0; i < 300 && !job_ready; i++) tick;
        if (!job_ready) begin
            checks++;
            errors++;
            $display("FAIL send_job: job_ready=%0b, required 1", job_ready);
        end
        tick;
        job_valid = 1'b0;
    endtask

    task automatic wait_result(input int limit, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < limit) begin
            tick;
            cyc++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_result: res_valid=0 after %0d cycles, required 1", cyc);
        end
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({job_ready, res_valid, rsa_start, res_status} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: {ready,valid,start,status}=%b, required 10000",
                     {job_ready, res_valid, rsa_start, res_status});
        end
        checks++;
        if ({res_data, res_tag, rsa_message, rsa_modulus, rsa_exponent} !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%h tag=%h msg=%h mod=%h exp=%h, required all 0",
                     res_data, res_tag, rsa_message, rsa_modulus, rsa_exponent);
        end
    endtask

    task automatic test_single;
        int cyc;
        int s0;
        do_reset;
        s0 = start_count;
        send_job(16'd5, 16'd13, 4'd3);
        wait_result(30, cyc);
        checks++;
        if (cyc !== 7) begin errors++; $display("FAIL single_latency: got %0d, required 7", cyc); end
        checks++;
        if (res_data !== 16'd8) begin errors++; $display("FAIL single_data: got %0d, required 8", res_data); end
        checks++;
        if (res_tag !== 8'd0) begin errors++; $display("FAIL single_tag: got %0d, required 0", res_tag); end
        checks++;
        if (res_status !== 2'b00) begin errors++; $display("FAIL single_status: got %b, required 00", res_status); end
        checks++;
        if (start_count - s0 !== 1) begin errors++; $display("FAIL single_start_cycles: got %0d, required 1", start_count - s0); end
        handshake;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b, required 0", res_valid); end
        checks++;
        if (rsa_modulus !== 16'd13) begin errors++; $display("FAIL single_operand_hold: got %0d, required 13", rsa_modulus); end
    endtask

    task automatic test_fifo_fill;
        logic [15:0] fill_exp [6];
        int cyc;
        fill_exp = '{16'd1, 16'd3, 16'd9, 16'd5, 16'd4, 16'd1};
        do_reset;
        for (int i = 0; i < 5; i++) send_job(16'd3, 16'd11, 4'(i));
        wait_result(30, cyc);
        job_message  = 16'd3;
        job_modulus  = 16'd11;
        job_exponent = 4'd5;
        job_valid    = 1'b1;
        tick;
        tick;
        checks++;
        if (job_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b, required 0", job_ready); end
        checks++;
        if (res_tag !== 8'd0) begin errors++; $display("FAIL fill_hold_tag: got %0d, required 0", res_tag); end
        job_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_result(40, cyc);
            checks++;
            if (res_data !== fill_exp[i]) begin
                errors++; $display("FAIL fill_data[%0d]: got %0d, required %0d", i, res_data, fill_exp[i]);
            end
            checks++;
            if (res_tag !== 8'(i)) begin errors++; $display("FAIL fill_tag[%0d]: got %0d, required %0d", i, res_tag, i); end
            checks++;
            if (res_status !== 2'b00) begin errors++; $display("FAIL fill_status[%0d]: got %b, required 00", i, res_status); end
            handshake;
            if (i == 0) begin
                tick;
                checks++;
                if (rsa_start !== 1'b1) begin errors++; $display("FAIL b2b_pop: rsa_start=%b, required 1", rsa_start); end
                send_job(16'd3, 16'd11, 4'd5);
            end
        end
    endtask

    task automatic test_bad_modulus;
        int cyc;
        int s0;
        do_reset;
        send_job(16'd5, 16'd13, 4'd3);
        wait_result(30, cyc);
        handshake;
        s0 = start_count;
        send_job(16'd7, 16'd1, 4'd2);
        wait_result(20, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL bad1_latency: got %0d, required 2", cyc); end
        checks++;
        if ({res_status, res_data} !== {2'b10, 16'd0}) begin
            errors++; $display("FAIL bad1_result: status=%b data=%0d, required 10/0", res_status, res_data);
        end
        checks++;
        if (res_tag !== 8'd1) begin errors++; $display("FAIL bad1_tag: got %0d, required 1", res_tag); end
        handshake;
        send_job(16'd9, 16'd0, 4'd1);
        wait_result(20, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL bad0_latency: got %0d, required 2", cyc); end
        checks++;
        if ({res_status, res_data, res_tag} !== {2'b10, 16'd0, 8'd2}) begin
            errors++; $display("FAIL bad0_result: status=%b data=%0d tag=%0d, required 10/0/2", res_status, res_data, res_tag);
        end
        checks++;
        if (start_count - s0 !== 0) begin errors++; $display("FAIL bad_no_start: got %0d, required 0", start_count - s0); end
        handshake;
    endtask

    task automatic test_timeout;
        int cyc;
        do_reset;
        host_mode = 1;
        send_job(16'd5, 16'd13, 4'd3);
        wait_result(100, cyc);
        checks++;
        if (cyc !== 66) begin errors++; $display("FAIL timeout_latency: got %0d, required 66", cyc); end
        checks++;
        if ({res_status, res_data, res_tag} !== {2'b01, 16'd0, 8'd0}) begin
            errors++; $display("FAIL timeout_result: status=%b data=%h tag=%0d, required 01/0/0", res_status, res_data, res_tag);
        end
        handshake;
        host_mode = 0;
        send_job(16'd5, 16'd13, 4'd3);
        wait_result(30, cyc);
        checks++;
        if ({res_status, res_data, res_tag} !== {2'b00, 16'd8, 8'd1} || cyc !== 7) begin
            errors++; $display("FAIL after_timeout: status=%b data=%0d tag=%0d lat=%0d, required 00/8/1/7",
                               res_status, res_data, res_tag, cyc);
        end
        handshake;
    endtask

    task automatic test_edge_concurrency;
        int  cyc;
        int  s0;
        logic seen;
        do_reset;
        host_mode = 2;
        send_job(16'd5, 16'd13, 4'd3);
        wait_result(100, cyc);
        checks++;
        if (cyc !== 66) begin errors++; $display("FAIL race_latency: got %0d, required 66", cyc); end
        checks++;
        if ({res_status, res_data} !== {2'b00, 16'd8}) begin
            errors++; $display("FAIL race_done_wins: status=%b data=%0d, required 00/8", res_status, res_data);
        end
        handshake;
        host_mode = 0;
        s0 = start_count;
        stray_req = 1'b1;
        tick;
        stray_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen = seen | res_valid;
        end
        checks++;
        if (seen !== 1'b0 || start_count - s0 !== 0) begin
            errors++; $display("FAIL stray_done: res_valid seen=%b starts=%0d, required 0/0", seen, start_count - s0);
        end
        send_job(16'd2, 16'd13, 4'd2);
        wait_result(30, cyc);
        checks++;
        if ({res_status, res_data, res_tag} !== {2'b00, 16'd4, 8'd1}) begin
            errors++; $display("FAIL after_stray: status=%b data=%0d tag=%0d, required 00/4/1", res_status, res_data, res_tag);
        end
        handshake;
    endtask

    task automatic test_reset_mid_wait;
        int   cyc;
        int   s0;
        logic seen;
        do_reset;
        send_job(16'd5, 16'd13, 4'd3);
        wait_result(30, cyc);
        handshake;
        host_mode = 1;
        send_job(16'd6, 16'd13, 4'd2);
        send_job(16'd7, 16'd13, 4'd1);
        for (int i = 0; i < 5; i++) tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({job_ready, res_valid, rsa_start, res_status} !== 5'b10000) begin
            errors++; $display("FAIL midwait_reset_ctrl: {ready,valid,start,status}=%b, required 10000",
                               {job_ready, res_valid, rsa_start, res_status});
        end
        checks++;
        if ({res_data, res_tag, rsa_message, rsa_modulus, rsa_exponent} !== '0) begin
            errors++; $display("FAIL midwait_reset_data: data=%h tag=%h msg=%h mod=%h exp=%h, required all 0",
                               res_data, res_tag, rsa_message, rsa_modulus, rsa_exponent);
        end
        tick;
        rst = 1'b0;
        host_mode = 0;
        s0 = start_count;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            seen = seen | res_valid;
        end
        checks++;
        if (seen !== 1'b0 || start_count - s0 !== 0) begin
            errors++; $display("FAIL midwait_fifo_empty: res_valid seen=%b starts=%0d, required 0/0", seen, start_count - s0);
        end
        send_job(16'd5, 16'd13, 4'd3);
        wait_result(30, cyc);
        checks++;
        if ({res_status, res_data, res_tag} !== {2'b00, 16'd8, 8'd0}) begin
            errors++; $display("FAIL midwait_next_job: status=%b data=%0d tag=%0d, required 00/8/0", res_status, res_data, res_tag);
        end
        handshake;
    endtask

    task automatic test_tag_wrap;
        int cyc;
        do_reset;
        for (int i = 0; i < 258; i++) begin
            send_job(16'(i), 16'd1, 4'd0);
            wait_result(20, cyc);
            checks++;
            if (res_tag !== 8'(i)) begin errors++; $display("FAIL tag_wrap[%0d]: got %0d, required %0d", i, res_tag, i % 256); end
            handshake;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fifo_fill;
        test_bad_modulus;
        test_timeout;
        test_edge_concurrency;
        test_reset_mid_wait;
        test_tag_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
